mix_columns_iter: RTL and testbench

- Iterative, parametrised successor of the Blink column-mixing diffusion layer.
- Applies the involutive column map to a state of PLANES 64-bit planes of 4x4 cells. Each output cell is the XOR of the other three cells in its column.
- Processes COLS_PER_CYCLE columns per clock, trading area for latency, behind valid/ready handshakes on both sides.
- Sits between the S-box layer and the key-add stage of the round datapath. It also has a per-transaction bypass for rounds without diffusion.

---
 rtl/mix_columns_iter_if.sv | 24 ++
 rtl/mix_columns_iter.sv | 107 ++++++++++
 tb/tb_mix_columns_iter.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mix_columns_iter_if.sv
// Stream handshake bundle for the iterative column-mixing layer.
// The slave modport is the block's view; the master modport is the producer/consumer side.
interface mix_columns_iter_if #(
   parameter int W = 64
);
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] in_data;
   logic         in_bypass;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_data;
   logic         busy;

   modport slave (
      input  in_valid, in_data, in_bypass, out_ready,
      output in_ready, out_valid, out_data, busy
   );

   modport master (
      output in_valid, in_data, in_bypass, out_ready,
      input  in_ready, out_valid, out_data, busy
   );
endinterface

// File: rtl/mix_columns_iter.sv
// Iterative involutive column mix: each output cell is the XOR of the other three cells
// in its column, processed COLS_PER_CYCLE columns per clock.
//
// state  | meaning
// S_IDLE | waiting for a word, in_ready=1
// S_BUSY | mixing one column group per cycle
// S_DONE | result presented, in_ready follows out_ready
module mix_columns_iter #(
   parameter int M              = 4,
   parameter int PLANES         = 1,
   parameter int COLS_PER_CYCLE = 1
) (
   input  logic             clk,
   input  logic             rst,
   mix_columns_iter_if.slave bus
);
   localparam int W    = 16 * M * PLANES;
   localparam int NCOL = 4 * PLANES;
   localparam int S    = NCOL / COLS_PER_CYCLE;
   localparam int CW   = (S > 1) ? $clog2(S) : 1;

   if (COLS_PER_CYCLE < 1 || (NCOL % COLS_PER_CYCLE) != 0) begin : g_bad_cols
      $error("COLS_PER_CYCLE must divide 4*PLANES");
   end

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

   state_t          r_state;
   logic [CW-1:0]   r_cnt;
   logic [W-1:0]    r_data;
   logic            r_out_valid;
   logic            r_busy;

   logic            w_accept;
   logic            w_last;
   logic [W-1:0]    w_mixed;

   assign bus.in_ready  = (r_state == S_IDLE) || ((r_state == S_DONE) && bus.out_ready);
   assign bus.out_valid = r_out_valid;
   assign bus.out_data  = r_data;
   assign bus.busy      = r_busy;

   assign w_accept = bus.in_valid && bus.in_ready;
   assign w_last   = (r_cnt == CW'(S - 1));

   // Every column has its mix prepared; only the active group is written back.
   for (genvar g = 0; g < NCOL; g++) begin : g_col
      localparam int L   = g / 4;
      localparam int C   = g % 4;
      localparam int GRP = g / COLS_PER_CYCLE;
      logic [M-1:0] w_x;
      logic         w_sel;

      assign w_x   = r_data[M*(16*L + C)      +: M] ^ r_data[M*(16*L + 4 + C)  +: M]
                   ^ r_data[M*(16*L + 8 + C)  +: M] ^ r_data[M*(16*L + 12 + C) +: M];
      assign w_sel = (r_cnt == CW'(GRP));

      for (genvar gr = 0; gr < 4; gr++) begin : g_row
         assign w_mixed[M*(16*L + 4*gr + C) +: M] =
            w_sel ? (w_x ^ r_data[M*(16*L + 4*gr + C) +: M]) : r_data[M*(16*L + 4*gr + C) +: M];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_data      <= '0;
         r_out_valid <= 1'b0;
         r_busy      <= 1'b0;
      end else if (w_accept) begin
         r_data <= bus.in_data;
         r_cnt  <= '0;
         if (bus.in_bypass) begin
            r_state     <= S_DONE;
            r_out_valid <= 1'b1;
            r_busy      <= 1'b0;
         end else begin
            r_state     <= S_BUSY;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b1;
         end
      end else begin
         case (r_state)
            S_BUSY: begin
               r_data <= w_mixed;
               if (w_last) begin
                  r_cnt       <= '0;
                  r_state     <= S_DONE;
                  r_out_valid <= 1'b1;
                  r_busy      <= 1'b0;
               end else begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            S_DONE: begin
               if (bus.out_ready) begin
                  r_state     <= S_IDLE;
                  r_out_valid <= 1'b0;
               end
            end
            default: begin
            end
         endcase
      end
   end
endmodule

// File: tb/tb_mix_columns_iter.sv
// Bench for mix_columns_iter: directed scenarios plus randomized handshake stress on
// a 64-bit (1 column/cycle) and a 128-bit (4 columns/cycle) instance.
module tb_mix_columns_iter;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   mix_columns_iter_if #(.W(64))  ifa ();
   mix_columns_iter_if #(.W(128)) ifb ();

   mix_columns_iter #(.M(4), .PLANES(1), .COLS_PER_CYCLE(1)) dut_a (
      .clk(clk), .rst(rst), .bus(ifa.slave)
   );
   mix_columns_iter #(.M(4), .PLANES(2), .COLS_PER_CYCLE(4)) dut_b (
      .clk(clk), .rst(rst), .bus(ifb.slave)
   );

   // Reference: for every column, out_r = (r0^r1^r2^r3) ^ in_r.
   function automatic logic [127:0] ref_mix(input logic [127:0] d, input int planes);
      logic [127:0] o;
      logic [3:0]   col [4];
      logic [3:0]   x;
      o = d;
      for (int l = 0; l < planes; l++) begin
         for (int c = 0; c < 4; c++) begin
            x = 4'h0;
            for (int r = 0; r < 4; r++) begin
               col[r] = 4'((d >> (4 * (16*l + 4*r + c))) & 128'hF);
               x      = x ^ col[r];
            end
            for (int r = 0; r < 4; r++) o[4*(16*l + 4*r + c) +: 4] = x ^ col[r];
         end
      end
      return o;
   endfunction

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic do_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic send_a(input logic [63:0] d, input logic byp,
                         output logic [63:0] res, output int lat, output int nbusy);
      int guard;
      @(negedge clk);
      guard = 0;
      while (ifa.in_ready !== 1'b1 && guard < 100) begin @(negedge clk); guard++; end
      total++;
      if (guard >= 100) begin bad++; $display("FAIL send_a_ready in_ready=%b required=1", ifa.in_ready); end
      ifa.in_valid = 1'b1; ifa.in_data = d; ifa.in_bypass = byp;
      @(posedge clk);
      #1 ifa.in_valid = 1'b0; ifa.in_bypass = 1'b0;
      lat = 0; nbusy = 0;
      while (lat < 100) begin
         @(negedge clk);
         lat++;
         if (ifa.busy === 1'b1) nbusy++;
         if (ifa.out_valid === 1'b1) break;
      end
      res = ifa.out_data;
   endtask

   task automatic send_b(input logic [127:0] d, input logic byp,
                         output logic [127:0] res, output int lat);
      int guard;
      @(negedge clk);
      guard = 0;
      while (ifb.in_ready !== 1'b1 && guard < 100) begin @(negedge clk); guard++; end
      total++;
      if (guard >= 100) begin bad++; $display("FAIL send_b_ready in_ready=%b required=1", ifb.in_ready); end
      ifb.in_valid = 1'b1; ifb.in_data = d; ifb.in_bypass = byp;
      @(posedge clk);
      #1 ifb.in_valid = 1'b0; ifb.in_bypass = 1'b0;
      lat = 0;
      while (lat < 100) begin
         @(negedge clk);
         lat++;
         if (ifb.out_valid === 1'b1) break;
      end
      res = ifb.out_data;
   endtask

   task automatic test_reset();
      do_reset();
      @(negedge clk);
      total++; if (ifa.out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b exp=0", ifa.out_valid); end
      total++; if (ifa.busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", ifa.busy); end
      total++; if (ifa.in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%b exp=1", ifa.in_ready); end
      total++; if (ifa.out_data !== 64'h0) begin bad++; $display("FAIL rst_out_data got=%h exp=0", ifa.out_data); end
      total++; if (ifb.out_valid !== 1'b0) begin bad++; $display("FAIL rst_b_out_valid got=%b exp=0", ifb.out_valid); end
      total++; if (ifb.in_ready !== 1'b1) begin bad++; $display("FAIL rst_b_in_ready got=%b exp=1", ifb.in_ready); end
   endtask

   task automatic test_impulse();
      logic [63:0] res;
      int lat, nb;
      send_a(64'h000000000000000F, 1'b0, res, lat, nb);
      total++; if (res !== 64'h000F000F000F0000) begin bad++; $display("FAIL impulse_data got=%h exp=000f000f000f0000", res); end
      total++; if (lat !== 5) begin bad++; $display("FAIL impulse_latency got=%0d exp=5", lat); end
      total++; if (nb !== 4) begin bad++; $display("FAIL impulse_busy_cycles got=%0d exp=4", nb); end
   endtask

   task automatic test_involution();
      logic [63:0]  ra, r1;
      logic [127:0] d, rb, exp_b;
      int lat, nb;
      send_a(64'hFFFFFFFFFFFFFFFF, 1'b0, ra, lat, nb);
      total++; if (ra !== 64'hFFFFFFFFFFFFFFFF) begin bad++; $display("FAIL all_ones got=%h exp=ffffffffffffffff", ra); end
      send_a(64'h0123456789ABCDEF, 1'b0, r1, lat, nb);
      exp_b = ref_mix({64'h0, 64'h0123456789ABCDEF}, 1);
      total++; if (r1 !== exp_b[63:0]) begin bad++; $display("FAIL mix_pattern got=%h exp=%h", r1, exp_b[63:0]); end
      send_a(r1, 1'b0, ra, lat, nb);
      total++; if (ra !== 64'h0123456789ABCDEF) begin bad++; $display("FAIL involution_a got=%h exp=0123456789abcdef", ra); end
      for (int i = 0; i < 3; i++) begin
         d = rnd128();
         send_b(d, 1'b0, rb, lat);
         exp_b = ref_mix(d, 2);
         total++; if (rb !== exp_b) begin bad++; $display("FAIL mix_b got=%h exp=%h", rb, exp_b); end
         total++; if (lat !== 3) begin bad++; $display("FAIL latency_b got=%0d exp=3", lat); end
         send_b(rb, 1'b0, rb, lat);
         total++; if (rb !== d) begin bad++; $display("FAIL involution_b got=%h exp=%h", rb, d); end
      end
   endtask

   task automatic test_bypass();
      logic [63:0] res;
      int lat, nb;
      send_a(64'hDEADBEEFCAFEF00D, 1'b1, res, lat, nb);
      total++; if (res !== 64'hDEADBEEFCAFEF00D) begin bad++; $display("FAIL bypass_data got=%h exp=deadbeefcafef00d", res); end
      total++; if (lat !== 1) begin bad++; $display("FAIL bypass_latency got=%0d exp=1", lat); end
   endtask

   task automatic test_back_to_back();
      logic [63:0] w [8];
      for (int k = 0; k < 8; k++) w[k] = {$urandom, $urandom};
      @(negedge clk);
      ifa.out_ready = 1'b1;
      for (int k = 0; k <= 8; k++) begin
         if (k > 0) begin
            total++;
            if (ifa.out_valid !== 1'b1 || ifa.out_data !== w[k-1]) begin
               bad++; $display("FAIL b2b_word%0d valid=%b got=%h exp=%h", k-1, ifa.out_valid, ifa.out_data, w[k-1]);
            end
         end
         if (k < 8) begin ifa.in_valid = 1'b1; ifa.in_data = w[k]; ifa.in_bypass = 1'b1; end
         else begin ifa.in_valid = 1'b0; ifa.in_bypass = 1'b0; end
         @(negedge clk);
      end
   endtask

   task automatic test_backpressure();
      logic [63:0]  d, nw, res;
      logic [127:0] exp_m;
      int lat, nb;
      d  = {$urandom, $urandom};
      nw = {$urandom, $urandom};
      exp_m = ref_mix({64'h0, d}, 1);
      ifa.out_ready = 1'b0;
      send_a(d, 1'b0, res, lat, nb);
      total++; if (res !== exp_m[63:0] || lat !== 5) begin bad++; $display("FAIL bp_first got=%h lat=%0d exp=%h lat=5", res, lat, exp_m[63:0]); end
      ifa.in_valid = 1'b1; ifa.in_data = ~nw; ifa.in_bypass = 1'b1;
      for (int i = 0; i < 10; i++) begin
         total++;
         if (ifa.out_valid !== 1'b1 || ifa.out_data !== exp_m[63:0] || ifa.in_ready !== 1'b0) begin
            bad++; $display("FAIL bp_hold cyc%0d valid=%b ready=%b got=%h exp=%h", i, ifa.out_valid, ifa.in_ready, ifa.out_data, exp_m[63:0]);
         end
         @(negedge clk);
      end
      ifa.out_ready = 1'b1; ifa.in_data = nw;
      #1;
      total++; if (ifa.in_ready !== 1'b1) begin bad++; $display("FAIL bp_release_ready got=%b exp=1", ifa.in_ready); end
      @(posedge clk);
      #1 ifa.in_valid = 1'b0; ifa.in_bypass = 1'b0;
      @(negedge clk);
      total++; if (ifa.out_valid !== 1'b1 || ifa.out_data !== nw) begin bad++; $display("FAIL bp_same_edge valid=%b got=%h exp=%h", ifa.out_valid, ifa.out_data, nw); end
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      ifa.in_valid = 1'b1; ifa.in_data = {$urandom, $urandom}; ifa.in_bypass = 1'b0;
      @(posedge clk);
      #1 ifa.in_valid = 1'b0;
      repeat (3) @(negedge clk);
      total++; if (ifa.busy !== 1'b1 || dut_a.r_cnt !== 2'd2) begin bad++; $display("FAIL mid_busy busy=%b cnt=%0d exp busy=1 cnt=2", ifa.busy, dut_a.r_cnt); end
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      total++;
      if (ifa.out_valid !== 1'b0 || ifa.in_ready !== 1'b1 || ifa.busy !== 1'b0 || ifa.out_data !== 64'h0) begin
         bad++; $display("FAIL mid_reset valid=%b ready=%b busy=%b data=%h exp 0 1 0 0", ifa.out_valid, ifa.in_ready, ifa.busy, ifa.out_data);
      end
      test_impulse();
   endtask

   task automatic test_stress(input bit sel, input int nwords);
      logic [127:0] q [$];
      int           qc [$];
      logic [127:0] d, od;
      logic         ov, ordy, ival, byp, ird, seen;
      int           acc_n, del_n, guard, planes, s;
      planes = sel ? 2 : 1;
      s      = sel ? 2 : 4;
      acc_n = 0; del_n = 0; guard = 0; seen = 1'b0;
      while ((acc_n < nwords || q.size() > 0) && guard < nwords*12 + 200) begin
         @(negedge clk);
         guard++;
         ov = sel ? ifb.out_valid : ifa.out_valid;
         od = sel ? ifb.out_data  : {64'h0, ifa.out_data};
         if (ov === 1'b1 && !seen) begin
            total++;
            if (q.size() == 0) begin bad++; $display("FAIL stress%0d_spurious valid with no word pending", sel); end
            else if (cyc !== qc[0]) begin bad++; $display("FAIL stress%0d_latency got_cycle=%0d exp_cycle=%0d", sel, cyc, qc[0]); end
            seen = 1'b1;
         end
         ordy = ($urandom_range(3) != 0);
         ival = (acc_n < nwords) && ($urandom_range(3) != 0);
         byp  = 1'($urandom_range(1));
         d    = sel ? rnd128() : {64'h0, $urandom, $urandom};
         if (sel) begin ifb.out_ready = ordy; ifb.in_valid = ival; ifb.in_bypass = byp; ifb.in_data = d; end
         else begin ifa.out_ready = ordy; ifa.in_valid = ival; ifa.in_bypass = byp; ifa.in_data = d[63:0]; end
         #1;
         ird = sel ? ifb.in_ready : ifa.in_ready;
         if (ov === 1'b1 && ordy) begin
            total++;
            if (q.size() == 0) begin bad++; $display("FAIL stress%0d_extra got=%h", sel, od); end
            else begin
               if (od !== q[0]) begin bad++; $display("FAIL stress%0d_data word%0d got=%h exp=%h", sel, del_n, od, q[0]); end
               void'(q.pop_front());
               void'(qc.pop_front());
            end
            del_n++;
            seen = 1'b0;
         end
         if (ival && ird === 1'b1) begin
            q.push_back(byp ? d : ref_mix(d, planes));
            qc.push_back(cyc + (byp ? 1 : s + 1));
            acc_n++;
         end
      end
      if (sel) begin ifb.in_valid = 1'b0; ifb.out_ready = 1'b1; end
      else begin ifa.in_valid = 1'b0; ifa.out_ready = 1'b1; end
      total++;
      if (del_n !== nwords || q.size() != 0) begin
         bad++; $display("FAIL stress%0d_count delivered=%0d pending=%0d exp delivered=%0d pending=0", sel, del_n, q.size(), nwords);
      end
      @(negedge clk);
   endtask

   initial begin
      ifa.in_valid = 1'b0; ifa.in_data = '0; ifa.in_bypass = 1'b0; ifa.out_ready = 1'b1;
      ifb.in_valid = 1'b0; ifb.in_data = '0; ifb.in_bypass = 1'b0; ifb.out_ready = 1'b1;
      test_reset();
      test_impulse();
      test_involution();
      test_bypass();
      test_back_to_back();
      test_backpressure();
      test_reset_mid();
      test_stress(1'b0, 3000);
      test_stress(1'b1, 3000);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #1500000;
      $display("FAIL watchdog simulation time limit reached total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end
endmodule
